// File: rtl/ssd_pkg.sv
// rtl/ssd_pkg.sv - shared types, digit codes and segment patterns for the scan driver
package ssd_pkg;

  // Conversion engine states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_e;

  // Internal digit codes: 0..9 are the decimal digit itself
  localparam logic [3:0] CODE_DASH  = 4'hA;
  localparam logic [3:0] CODE_BLANK = 4'hF;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Any code outside 0..9 and dash renders as blank
  function automatic logic [6:0] code_to_seg(input logic [3:0] code);
    case (code)
      4'd0:      return SEG_0;
      4'd1:      return SEG_1;
      4'd2:      return SEG_2;
      4'd3:      return SEG_3;
      4'd4:      return SEG_4;
      4'd5:      return SEG_5;
      4'd6:      return SEG_6;
      4'd7:      return SEG_7;
      4'd8:      return SEG_8;
      4'd9:      return SEG_9;
      CODE_DASH: return SEG_DASH;
      default:   return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/ssd_scan_driver_bin2bcd_seq.sv
// rtl/ssd_scan_driver_bin2bcd_seq.sv - sequential shift-add-3 binary to BCD engine
module bin2bcd_seq
  import ssd_pkg::*;
#(
  parameter int DATA_W     = 14,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [DATA_W-1:0]       bin,
  output logic                    busy,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] bcd
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  conv_state_e             state_q;
  logic [DATA_W-1:0]       bin_q;
  logic [4*NUM_DIGITS-1:0] bcd_q;
  logic [4*NUM_DIGITS-1:0] bcd_adj;
  logic [CNT_W-1:0]        cnt_q;
  logic                    busy_q;
  logic                    done_q;

  // Add 3 to every nibble that would reach 10 or more after the next doubling
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Conversion FSM: capture, DATA_W adjust-and-shift iterations, one cycle of done
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            bin_q   <= bin;
            bcd_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          {bcd_q, bin_q} <= {bcd_adj[4*NUM_DIGITS-2:0], bin_q, 1'b0};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;

endmodule

// File: rtl/ssd_scan_driver.sv
// rtl/ssd_scan_driver.sv - multiplexed seven-segment driver with BCD conversion
module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DATA_W     = 14,
  parameter int MAX_VAL    = 9999,
  parameter int LZ_BLANK   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scan_tick,
  input  logic [DATA_W-1:0]     value,
  input  logic                  load,
  output logic [NUM_DIGITS-1:0] anode,
  output logic [6:0]            seg,
  output logic                  busy,
  output logic                  ovf
);

  localparam int PTR_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(NUM_DIGITS - 1);
  localparam logic [DATA_W-1:0] MAX_V    = DATA_W'(MAX_VAL);

  logic                         scan_q, scan_d;
  logic                         started_q, started_d;
  logic [PTR_W-1:0]             ptr_q, ptr_d;
  logic [NUM_DIGITS-1:0][3:0]   disp_q, disp_d;
  logic [NUM_DIGITS-1:0][3:0]   conv_codes;
  logic [NUM_DIGITS-1:0]        anode_q, anode_d;
  logic [6:0]                   seg_q, seg_d;
  logic                         ovf_q, ovf_d;
  logic                         blank_run;
  logic                         over_load;
  logic                         eng_start;
  logic                         eng_busy;
  logic                         eng_done;
  logic [4*NUM_DIGITS-1:0]      eng_bcd;

  // Oversized values never reach the engine; they turn into a dash display instead
  assign over_load = load & ~eng_busy & (value > MAX_V);
  assign eng_start = load & ~eng_busy & ~(value > MAX_V);

  bin2bcd_seq #(
    .DATA_W     (DATA_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (eng_start),
    .bin   (value),
    .busy  (eng_busy),
    .done  (eng_done),
    .bcd   (eng_bcd)
  );

  // Map finished BCD onto digit codes, blanking leading zeros above digit 0
  always_comb begin
    blank_run  = 1'b1;
    conv_codes = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (LZ_BLANK != 0 && i != 0 && blank_run && eng_bcd[4*i +: 4] == 4'd0) begin
        conv_codes[i] = CODE_BLANK;
      end else begin
        conv_codes[i] = eng_bcd[4*i +: 4];
        blank_run     = 1'b0;
      end
    end
  end

  // Next-state: tick edge detect, pointer, display register, ovf and outputs
  always_comb begin
    scan_d    = scan_tick;
    started_d = started_q;
    ptr_d     = ptr_q;
    if (scan_tick && !scan_q) begin
      if (!started_q) begin
        started_d = 1'b1;
      end else if (ptr_q == PTR_LAST) begin
        ptr_d = '0;
      end else begin
        ptr_d = ptr_q + 1'b1;
      end
    end

    disp_d = disp_q;
    ovf_d  = ovf_q;
    if (over_load) begin
      ovf_d = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        disp_d[i] = CODE_DASH;
      end
    end else if (eng_start) begin
      ovf_d = 1'b0;
    end
    if (eng_done) begin
      disp_d = conv_codes;
    end

    anode_d = '1;
    seg_d   = SEG_BLANK;
    if (started_d) begin
      anode_d[ptr_d] = 1'b0;
      seg_d          = code_to_seg(disp_d[ptr_d]);
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_q    <= 1'b0;
      started_q <= 1'b0;
      ptr_q     <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        disp_q[i] <= (i == 0 || LZ_BLANK == 0) ? 4'd0 : CODE_BLANK;
      end
      anode_q <= '1;
      seg_q   <= SEG_BLANK;
      ovf_q   <= 1'b0;
    end else begin
      scan_q    <= scan_d;
      started_q <= started_d;
      ptr_q     <= ptr_d;
      disp_q    <= disp_d;
      anode_q   <= anode_d;
      seg_q     <= seg_d;
      ovf_q     <= ovf_d;
    end
  end

  assign anode = anode_q;
  assign seg   = seg_q;
  assign busy  = eng_busy;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// tb/tb_ssd_scan_driver.sv - scoreboard bench for ssd_scan_driver
module tb_ssd_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        scan_tick;
  logic [13:0] value;
  logic        load;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        busy;
  logic        ovf;

  int n_tests = 0;
  int n_fail  = 0;
  int edge_cnt = 0;

  typedef struct {
    int         edge_no;
    logic [3:0] anode;
    logic [6:0] seg;
    logic       busy;
    logic       ovf;
  } exp_t;

  exp_t sb[$];

  ssd_scan_driver dut (
    .clk       (clk),
    .rst       (rst),
    .scan_tick (scan_tick),
    .value     (value),
    .load      (load),
    .anode     (anode),
    .seg       (seg),
    .busy      (busy),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Reference model state: what the board should show, in decimal terms
  bit m_started, m_ovf, m_prev;
  int m_ptr, m_busy_left, m_pend;
  int m_dig[4];
  int tp = 4;
  int tcnt = 0;

  function automatic logic [6:0] seg_of(input int c);
    case (c)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      10: return 7'b0111111;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic render(input int v);
    int p;
    p = 1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0 && v < p) m_dig[i] = 15;
      else m_dig[i] = (v / p) % 10;
      p = p * 10;
    end
  endtask

  task automatic model_step(input bit r, input bit t, input bit ld, input int v);
    if (r) begin
      m_started = 0; m_ovf = 0; m_prev = 0; m_ptr = 0; m_busy_left = 0; m_pend = 0;
      render(0);
    end else begin
      if (t && !m_prev) begin
        if (!m_started) m_started = 1;
        else m_ptr = (m_ptr + 1) % 4;
      end
      m_prev = t;
      if (m_busy_left > 0) begin
        m_busy_left--;
        if (m_busy_left == 0) render(m_pend);
      end else if (ld) begin
        if (v > 9999) begin
          m_ovf = 1;
          for (int i = 0; i < 4; i++) m_dig[i] = 10;
        end else begin
          m_ovf = 0;
          m_pend = v;
          m_busy_left = 15;
        end
      end
    end
  endtask

  // One clock of stimulus; the model's expected outputs for that edge go to the scoreboard
  task automatic cyc(input bit r, input bit ld, input int v);
    bit t;
    exp_t e;
    t = ((tcnt % tp) < (tp / 2));
    tcnt++;
    rst = r; load = ld; value = v[13:0]; scan_tick = t;
    model_step(r, t, ld, v);
    e.edge_no = edge_cnt + 1;
    e.anode   = m_started ? ~(4'b0001 << m_ptr) : 4'hF;
    e.seg     = m_started ? seg_of(m_dig[m_ptr]) : 7'h7F;
    e.busy    = (m_busy_left > 0);
    e.ovf     = m_ovf;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, int'($urandom_range(0, 16383)));
  endtask

  task automatic chk(input string nm, input int edge_no, input logic [6:0] act, input logic [6:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got %b expected %b", nm, edge_no, act, exp);
    end
  endtask

  // Monitor: compare DUT outputs against the scoreboard entry for the edge just taken
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].edge_no <= edge_cnt) begin
      exp_t e;
      e = sb.pop_front();
      chk("anode", e.edge_no, {3'b0, anode}, {3'b0, e.anode});
      chk("seg",   e.edge_no, seg, e.seg);
      chk("busy",  e.edge_no, {6'b0, busy}, {6'b0, e.busy});
      chk("ovf",   e.edge_no, {6'b0, ovf}, {6'b0, e.ovf});
    end
  end

  initial begin
    int v;
    rst = 1; load = 0; value = 0; scan_tick = 0;
    @(posedge clk); #1;
    cyc(1, 0, 0); cyc(1, 0, 0);
    tcnt = 2;
    idle(14);
    cyc(0, 1, 1234); idle(40);
    cyc(0, 1, 10000); idle(30);
    cyc(0, 1, 7); idle(40);
    cyc(0, 1, 56); idle(2); cyc(0, 1, 99); idle(30);
    cyc(0, 1, 9999); idle(6); cyc(1, 0, 0); idle(12);
    while ((tcnt % 4) != 1) idle(1);
    cyc(0, 1, 4321); idle(30);
    cyc(0, 1, 0); idle(30);
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 79) == 0) tp = 2 * int'($urandom_range(1, 4));
      case ($urandom_range(0, 4))
        0: v = 9999;
        1: v = 10000;
        default: v = int'($urandom_range(0, 16383));
      endcase
      if ($urandom_range(0, 99) == 0) cyc(1, 0, v);
      else cyc(0, ($urandom_range(0, 7) == 0), v);
    end
    idle(3);
    @(negedge clk); #1;
    n_tests++;
    if (sb.size() > 1) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected at most 1", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ssd_scan_driver.md
Name: ssd_scan_driver

Overview:
- Four-digit multiplexed seven-segment display driver; consumes the divided scan clock (Q of CLK_divider) as a scan-rate tick, sampled in the clk domain.
- Converts a 14-bit binary value to BCD with a sequential shift-add-3 engine and drives active-low anodes and segments.
- Used to show PC, register or memory values from the pipelined core on the board display.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits; pointer width is clog2(NUM_DIGITS).
- DATA_W, 14, width of the binary input value.
- MAX_VAL, 9999, largest displayable value; anything larger is shown as overflow.
- LZ_BLANK, 1, when 1 leading zeros are blanked; digit 0 is always shown.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- scan_tick  input  1  divided clock from CLK_divider; level signal, synchronous to clk.
- value  input  DATA_W  binary value to display.
- load  input  1  capture request for value; ignored while busy.
- anode  output  NUM_DIGITS  digit enables, active-low, one-hot-low.
- seg  output  7  {g,f,e,d,c,b,a}, active-low.
- busy  output  1  conversion in progress.
- ovf  output  1  displayed value exceeded MAX_VAL.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: anode all 1s (all digits off), seg 7'b1111111, busy 0, ovf 0, digit pointer 0, display register holds value 0, scan_tick history register 0, FSM in IDLE.
- Scan path:
  - scan_q registers scan_tick. A rising edge (scan_tick=1 and scan_q=0) advances the pointer 0→1→…→NUM_DIGITS-1→0, wrapping.
  - anode and seg are registered, so they update one cycle after the edge-detect cycle.
  - anode[ptr]=0 and all other anode bits are 1. Until the first tick after reset, all digits stay off.
- Conversion FSM, states IDLE, SHIFT, DONE:
  - IDLE + load, value > MAX_VAL: set ovf=1 and load four dash codes into the display register on that edge. Stay in IDLE; busy stays 0.
  - IDLE + load, value ≤ MAX_VAL: capture value, clear the BCD scratch, iteration count=0, go to SHIFT, busy=1, ovf cleared.
  - SHIFT: one iteration per cycle. Add 3 to every BCD nibble ≥5, then shift {bcd,bin} left by 1. After DATA_W iterations, go to DONE.
  - DONE: write the display register atomically, applying leading-zero blanking, then go to IDLE with busy=0.
- Latency: load sampled at edge E0; iterations at E1..E14; display register written at E15. busy is high for exactly 15 cycles (after E0 through E15).
- Scanning is independent of conversion. The old display contents are shown until E15; no partial results are ever visible.
- load during SHIFT/DONE is ignored, with no queuing.
- A tick and a load in the same cycle are both honoured independently.
- Reset mid-conversion aborts it: busy=0 and the display returns to 0.
- Leading-zero blanking: with LZ_BLANK=1, a digit is blank when it and all higher digits are 0, except digit 0. The value 0 therefore shows as "   0".
- Segment encoding (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - dash=0111111, blank=1111111

Decomposition:
- Shared package ssd_pkg:
  - FSM state enum (IDLE/SHIFT/DONE).
  - 4-bit internal digit codes 0–9, CODE_DASH=4'hA, CODE_BLANK=4'hF.
  - Seven-segment constants for each code.
  - Function code_to_seg.
- One sub-module, bin2bcd_seq: the shift-add-3 engine with start/busy/done and a BCD output.
- The top level holds the edge detector, scan pointer, display register and output registers.

Test Plan:
- Reset, then 3 scan_tick rising edges with no load → anode 1110, 1101, 1011 in turn; seg is 1000000 on digit 0 and 1111111 on the other digits.
- load with value=1234 → busy high for 15 cycles. Over a full scan, digit3..0 segs are 1111001, 0100100, 0110000, 0011001.
- load with value=10000 → ovf=1, busy never asserts, and all four digits show 0111111. A later load of 7 clears ovf and shows "   7".
- load with 56, then load with 99 three cycles later → the second load is ignored and the display shows "  56".
- Assert rst at SHIFT iteration 6 of a 9999 conversion → next cycle busy=0, anode=1111, and after the next tick digit 0 shows 1000000.
- Tick on the same cycle as the DONE write, with 4 ticks per scan wrap → pointer wraps from 3 to 0 and the new digits appear cleanly on the next scan.
